// File: rtl/mips_prog_loader.sv
// Boot-and-observe controller for the pipelined MIPS32 core: clears/seeds the
// register file, streams a program into imem, runs the core, dumps a register window.
module mips_prog_loader #(
    parameter int DATA_W     = 32,
    parameter int IMEM_DEPTH = 1024,
    parameter int NREGS      = 32,
    parameter int INIT_MODE  = 1,
    parameter int DUMP_FIRST = 0,
    parameter int DUMP_COUNT = 6,
    parameter int TIMEOUT    = 4096,
    localparam int AW = $clog2(IMEM_DEPTH),
    localparam int RW = $clog2(NREGS),
    localparam int CW = $clog2(TIMEOUT + 1)
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              start,
    input  logic [AW:0]       prog_len,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              imem_we,
    output logic [AW-1:0]     imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              rf_we,
    output logic [RW-1:0]     rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              core_run,
    input  logic              core_halted,
    output logic              dump_valid,
    output logic [DATA_W-1:0] dump_data,
    output logic [RW-1:0]     dump_idx,
    input  logic              dump_ready,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err,
    output logic [CW-1:0]     run_cycles
);

    typedef enum logic [2:0] {
        IDLE, INIT_RF, LOAD, RUN, DUMP, DONE, ERR
    } state_t;

    state_t        state, nstate;
    logic [AW:0]   plen, lcnt;
    logic [RW-1:0] idx;         // shared by INIT_RF (write index) and DUMP (window offset)
    logic [CW-1:0] rcnt;
    logic          start_ok;

    assign start_ok = (prog_len != '0) && (prog_len <= (AW+1)'(IMEM_DEPTH));

    always_comb begin
        nstate     = state;
        load_ready = 1'b0;
        imem_we    = 1'b0;
        imem_addr  = '0;
        imem_wdata = '0;
        rf_we      = 1'b0;
        rf_addr    = '0;
        rf_wdata   = '0;
        core_run   = 1'b0;
        dump_valid = 1'b0;
        dump_data  = '0;
        dump_idx   = '0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                busy = 1'b0;
                done = (state == DONE);
                if (start)
                    nstate = start_ok ? INIT_RF : ERR;
            end
            INIT_RF: begin
                rf_we    = 1'b1;
                rf_addr  = idx;
                rf_wdata = (INIT_MODE != 0) ? DATA_W'(idx) : '0;
                if (idx == RW'(NREGS - 1))
                    nstate = LOAD;
            end
            LOAD: begin
                load_ready = 1'b1;
                imem_we    = load_valid;
                imem_addr  = lcnt[AW-1:0];
                imem_wdata = load_data;
                if (load_valid && lcnt == plen - 1'b1)
                    nstate = RUN;
            end
            RUN: begin
                core_run = 1'b1;
                // halt takes priority over a coincident timeout
                if (core_halted)
                    nstate = DUMP;
                else if (rcnt == CW'(TIMEOUT - 1))
                    nstate = ERR;
            end
            DUMP: begin
                rf_addr    = RW'(DUMP_FIRST) + idx;
                dump_valid = 1'b1;
                dump_idx   = RW'(DUMP_FIRST) + idx;
                dump_data  = rf_rdata;
                if (dump_ready && idx == RW'(DUMP_COUNT - 1))
                    nstate = DONE;
            end
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state      <= IDLE;
            plen       <= '0;
            lcnt       <= '0;
            idx        <= '0;
            rcnt       <= '0;
            run_cycles <= '0;
            err        <= 2'b00;
        end else begin
            state <= nstate;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        if (start_ok) begin
                            plen       <= prog_len;
                            lcnt       <= '0;
                            idx        <= '0;
                            rcnt       <= '0;
                            run_cycles <= '0;
                            err        <= 2'b00;
                        end else begin
                            err <= 2'b01;
                        end
                    end
                end
                INIT_RF: idx <= (idx == RW'(NREGS - 1)) ? '0 : idx + 1'b1;
                LOAD: if (load_valid) lcnt <= lcnt + 1'b1;
                RUN: begin
                    rcnt <= rcnt + 1'b1;
                    if (core_halted) begin
                        run_cycles <= rcnt + 1'b1;
                    end else if (rcnt == CW'(TIMEOUT - 1)) begin
                        run_cycles <= CW'(TIMEOUT);
                        err        <= 2'b10;
                    end
                end
                DUMP: if (dump_ready) idx <= idx + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Directed bench for mips_prog_loader with a small register file, imem and
// one-instruction-per-cycle core model.
module tb_mips_prog_loader;

    logic        clk1 = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [10:0] prog_len = '0;
    logic        load_valid = 1'b0;
    logic [31:0] load_data = '0;
    logic        load_ready, imem_we, rf_we, core_run, dump_valid, busy, done;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata, rf_wdata, rf_rdata, dump_data;
    logic [4:0]  rf_addr, dump_idx;
    logic        core_halted;
    logic        dump_ready = 1'b1;
    logic [1:0]  err;
    logic [5:0]  run_cycles;

    mips_prog_loader #(.TIMEOUT(50)) dut (
        .clk1(clk1), .rst(rst), .start(start), .prog_len(prog_len),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
        .core_run(core_run), .core_halted(core_halted),
        .dump_valid(dump_valid), .dump_data(dump_data), .dump_idx(dump_idx),
        .dump_ready(dump_ready), .busy(busy), .done(done), .err(err),
        .run_cycles(run_cycles)
    );

    always #5 clk1 = ~clk1;

    // ---------------- environment: rf, imem, core model, monitors ----------------
    logic [31:0] rf_m [32];
    logic [31:0] imem_m [1024];
    logic [9:0]  pc = '0;
    logic        halted = 1'b0;
    logic        core_hang = 1'b0;
    logic        imem_clr = 1'b0;
    logic [4:0]  rf_prev = '0;
    int rf_wr_cnt = 0, rf_bad = 0, imem_wr_cnt = 0, dn = 0, dv_cyc = 0, run_hi = 0;
    logic [4:0]  dq_idx [64];
    logic [31:0] dq_dat [64];

    assign rf_rdata    = rf_m[rf_addr];
    assign core_halted = halted;

    always @(posedge clk1) begin
        if (imem_clr)
            for (int i = 0; i < 1024; i++) imem_m[i] <= 32'hdeadbeef;
        if (rf_we) begin
            rf_m[rf_addr] <= rf_wdata;
            rf_wr_cnt     <= rf_wr_cnt + 1;
            rf_prev       <= rf_addr;
            if (rf_wdata != 32'(rf_addr) || (rf_addr != 0 && rf_addr != rf_prev + 5'd1))
                rf_bad <= rf_bad + 1;
        end
        if (imem_we) begin
            imem_m[imem_addr] <= imem_wdata;
            imem_wr_cnt       <= imem_wr_cnt + 1;
        end
        if (dump_valid) dv_cyc <= dv_cyc + 1;
        if (dump_valid && dump_ready) begin
            dq_idx[dn] <= dump_idx;
            dq_dat[dn] <= dump_data;
            dn         <= dn + 1;
        end
        if (core_run === 1'b1) run_hi <= run_hi + 1;
        if (core_run !== 1'b1) begin
            pc     <= '0;
            halted <= 1'b0;
        end else if (!halted) begin
            case (imem_m[pc][31:26])
                6'b001010: if (imem_m[pc][20:16] != 0)
                    rf_m[imem_m[pc][20:16]] <= rf_m[imem_m[pc][25:21]] + {{16{imem_m[pc][15]}}, imem_m[pc][15:0]};
                6'b000000: rf_m[imem_m[pc][15:11]] <= rf_m[imem_m[pc][25:21]] + rf_m[imem_m[pc][20:16]];
                6'b000011: rf_m[imem_m[pc][15:11]] <= rf_m[imem_m[pc][25:21]] | rf_m[imem_m[pc][20:16]];
                6'b111111: if (!core_hang) halted <= 1'b1;
                default: ;
            endcase
            pc <= pc + 10'd1;
        end
    end

    // ---------------- checking ----------------
    int nvec = 0, nbad = 0;
    logic [31:0] prog [9];
    int dexp [6] = '{0, 10, 20, 25, 30, 55};

    wire [138:0] all_out = {load_ready, imem_we, imem_addr, imem_wdata, rf_we, rf_addr,
                            rf_wdata, core_run, dump_valid, dump_data, dump_idx, busy,
                            done, err, run_cycles};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    typedef struct {
        logic        start;
        logic [10:0] plen;
        logic        exp_busy;
        logic [1:0]  exp_err;
        logic        exp_rfwe;
        int          exp_wr;
    } vec_t;
    vec_t vt [5];

    // One full session with prog_len=9; rst_after>0 aborts with rst after that many words.
    task automatic session(input bit tog, input bit hang, input bit stall, input int rst_after);
        int sent = 0, cyc = 0, k = 0, stall_left = 5;
        int rf0, im0, dn0, run0, dv0;
        bit lv, hs, stalling = 0;
        core_hang = hang;
        imem_clr = 1'b1;
        tick();
        imem_clr = 1'b0;
        rf0 = rf_wr_cnt; im0 = imem_wr_cnt; dn0 = dn; run0 = run_hi; dv0 = dv_cyc;
        prog_len = 11'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (sent < 9 && cyc < 200) begin
            lv = tog ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
            load_valid = lv;
            load_data  = prog[sent];
            #1;
            hs = lv && load_ready;
            tick();
            if (hs) sent++;
            cyc++;
            if (rst_after > 0 && sent == rst_after) break;
        end
        load_valid = 1'b0;
        if (rst_after > 0) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            chk("rst_midload_outs_nonzero", 64'(all_out != '0), 0);
            chk("rst_midload_imem_words", imem_wr_cnt - im0, 4);
            return;
        end
        chk("load_words_sent", sent, 9);
        while (!(done || err != 2'b00) && k < 300) begin
            dump_ready = 1'b1;
            if (stall && stall_left > 0 && (stalling || (dump_valid && dump_idx == 5'd2))) begin
                stalling = 1;
                dump_ready = 1'b0;
                chk("stall_valid", dump_valid, 1);
                chk("stall_idx", dump_idx, 2);
                chk("stall_data", dump_data, 20);
                stall_left--;
            end
            tick();
            k++;
        end
        dump_ready = 1'b1;
        chk("session_finished", k < 300, 1);
        chk("rf_writes", rf_wr_cnt - rf0, 32);
        chk("imem_writes", imem_wr_cnt - im0, 9);
        for (int i = 0; i < 9; i++) chk("imem_content", imem_m[i], prog[i]);
        if (hang) begin
            chk("to_err", err, 2);
            chk("to_run_cycles", run_cycles, 50);
            chk("to_core_run_cycles", run_hi - run0, 50);
            chk("to_done", done, 0);
            chk("to_dump_valid_cycles", dv_cyc - dv0, 0);
        end else begin
            chk("done", done, 1);
            chk("err", err, 0);
            chk("busy", busy, 0);
            chk("run_cycles", run_cycles, 10);
            chk("core_run_cycles", run_hi - run0, 10);
            chk("dump_words", dn - dn0, 6);
            for (int j = 0; j < 6; j++) begin
                chk("dump_idx", dq_idx[dn0 + j], j);
                chk("dump_data", dq_dat[dn0 + j], dexp[j]);
            end
            if (stall) chk("stall_cycles_seen", stall_left, 0);
        end
        chk("rf_sequence_errors", rf_bad, 0);
    endtask

    initial begin
        prog[0] = {6'b001010, 5'd0, 5'd1, 16'd10};        // ADDI R1,R0,10
        prog[1] = {6'b001010, 5'd0, 5'd2, 16'd20};        // ADDI R2,R0,20
        prog[2] = {6'b001010, 5'd0, 5'd3, 16'd25};        // ADDI R3,R0,25
        prog[3] = {6'b000011, 5'd7, 5'd7, 5'd7, 11'd0};   // OR R7,R7,R7
        prog[4] = {6'b000011, 5'd7, 5'd7, 5'd7, 11'd0};
        prog[5] = {6'b000000, 5'd1, 5'd2, 5'd4, 11'd0};   // ADD R4,R1,R2
        prog[6] = {6'b000011, 5'd7, 5'd7, 5'd7, 11'd0};
        prog[7] = {6'b000000, 5'd4, 5'd3, 5'd5, 11'd0};   // ADD R5,R4,R3
        prog[8] = {6'b111111, 26'd0};                     // HLT

        vt[0] = '{1'b0, 11'd9,    1'b0, 2'd0, 1'b0, 0};
        vt[1] = '{1'b1, 11'd0,    1'b0, 2'd1, 1'b0, 0};
        vt[2] = '{1'b1, 11'd1025, 1'b0, 2'd1, 1'b0, 0};
        vt[3] = '{1'b1, 11'd1024, 1'b1, 2'd0, 1'b1, 3};
        vt[4] = '{1'b1, 11'd1,    1'b1, 2'd0, 1'b1, 3};

        tick();
        tick();
        rst = 1'b0;
        chk("reset_outs_nonzero", 64'(all_out != '0), 0);

        for (int v = 0; v < 5; v++) begin
            int rf0, im0;
            rst = 1'b1;
            tick();
            rst = 1'b0;
            rf0 = rf_wr_cnt; im0 = imem_wr_cnt;
            start    = vt[v].start;
            prog_len = vt[v].plen;
            tick();
            start = 1'b0;
            chk($sformatf("vec%0d_busy", v), busy, vt[v].exp_busy);
            chk($sformatf("vec%0d_err", v), err, vt[v].exp_err);
            chk($sformatf("vec%0d_rf_we", v), rf_we, vt[v].exp_rfwe);
            tick(); tick(); tick();
            chk($sformatf("vec%0d_rf_writes", v), rf_wr_cnt - rf0, vt[v].exp_wr);
            chk($sformatf("vec%0d_imem_writes", v), imem_wr_cnt - im0, 0);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;

        session(1'b0, 1'b0, 1'b0, 0);   // streaming load
        session(1'b1, 1'b0, 1'b0, 0);   // load_valid 1,0,0,1
        session(1'b0, 1'b0, 1'b1, 0);   // dump stall on third word
        session(1'b0, 1'b1, 1'b0, 0);   // core never halts
        session(1'b0, 1'b0, 1'b0, 4);   // reset mid-LOAD
        session(1'b0, 1'b0, 1'b0, 0);   // fresh session after abort

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule

// File: doc/mips_prog_loader.md
Name: mips_prog_loader

Overview:
- Synthesizable boot-and-observe controller for the pipelined MIPS32 core.
- Initialises the core register file, streams a program image into instruction memory over a valid/ready channel, then releases the core and measures run length.
- On HLT, streams a configurable window of registers out over a second valid/ready channel; aborts on timeout.
- Sits between the host or test harness and the core's Reg/Mem write ports. Single-clock domain.

Parameters:
- DATA_W, 32, register and instruction word width.
- IMEM_DEPTH, 1024, instruction memory words; AW = clog2(IMEM_DEPTH).
- NREGS, 32, register file entries; RW = clog2(NREGS).
- INIT_MODE, 1, 0: registers cleared to 0; 1: Reg[k] = k.
- DUMP_FIRST, 0, first register index dumped.
- DUMP_COUNT, 6, number of registers dumped; DUMP_FIRST+DUMP_COUNT <= NREGS.
- TIMEOUT, 4096, maximum RUN cycles before abort; CW = clog2(TIMEOUT+1).

Ports:
- clk1  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a session; sampled only in IDLE, DONE or ERR.
- prog_len  in  AW+1  program word count; sampled with start.
- load_valid  in  1  program word valid.
- load_data  in  DATA_W  program word.
- load_ready  out  1  loader accepts a word.
- imem_we  out  1  instruction memory write strobe.
- imem_addr  out  AW  instruction memory address.
- imem_wdata  out  DATA_W  instruction memory data.
- rf_we  out  1  register file write strobe.
- rf_addr  out  RW  register file address (write and read).
- rf_wdata  out  DATA_W  register file write data.
- rf_rdata  in  DATA_W  asynchronous register file read data for rf_addr.
- core_run  out  1  1 releases the core; 0 holds it with PC=0 and TAKEN_BRANCH=0.
- core_halted  in  1  core HALTED flag.
- dump_valid  out  1  dump word valid.
- dump_data  out  DATA_W  dumped register value.
- dump_idx  out  RW  index of the dumped register.
- dump_ready  in  1  consumer accepts the dump word.
- busy  out  1  state is not IDLE, DONE or ERR.
- done  out  1  session completed normally.
- err  out  2  00 none, 01 bad prog_len, 10 timeout.
- run_cycles  out  CW  cycles spent in RUN, latched on exit.

Behaviour:
- Reset: state IDLE. Every output is 0, including err and run_cycles. Counters are cleared. Memory contents are not cleared.
- Reset during any state aborts immediately, drops core_run and drops dump_valid. A partly loaded image stays in memory.
- States: IDLE, INIT_RF, LOAD, RUN, DUMP, DONE, ERR.
- IDLE/DONE/ERR with start=1:
  - If prog_len==0 or prog_len>IMEM_DEPTH: go to ERR with err=01.
  - Otherwise latch prog_len, clear done, err and run_cycles, and go to INIT_RF.
  - start is ignored in all other states.
- INIT_RF:
  - Lasts exactly NREGS cycles: rf_we=1, rf_addr=i (i = 0..NREGS-1), rf_wdata = INIT_MODE ? i : 0. R0 is written too.
  - Then go to LOAD.
- LOAD:
  - load_ready=1 throughout.
  - A word transfers when load_valid and load_ready are both 1 on a rising edge. Each transfer drives imem_we=1, imem_addr=cnt, imem_wdata=load_data for that cycle combinationally, then cnt increments.
  - Back-pressure is not applied. Idle cycles (load_valid=0) are allowed without limit.
  - After the prog_len-th transfer, load_ready drops and the FSM goes to RUN on the next cycle.
- RUN:
  - core_run=1 and a cycle counter increments each cycle.
  - core_halted sampled 1: latch the count into run_cycles, drop core_run, go to DUMP.
  - Counter reaches TIMEOUT with core_halted=0: latch run_cycles=TIMEOUT, drop core_run, err=10, go to ERR.
  - If halt and timeout occur in the same cycle, halt wins.
- DUMP:
  - rf_addr = DUMP_FIRST+j, dump_idx = rf_addr, dump_data = rf_rdata, dump_valid=1.
  - dump_data and dump_idx stay stable while dump_valid=1 and dump_ready=0.
  - On a handshake, j increments. After DUMP_COUNT handshakes (back-to-back allowed), go to DONE.
  - rf_we=0 throughout.
- DONE: done=1 and busy=0, held until the next start or rst.
- ERR: err holds its code and busy=0 until the next accepted start or rst.

Test Plan:
- INIT_MODE=1, prog_len=9, 9-word ADDI/OR/ADD/HLT program, load_valid always 1, core model, dump_ready=1.
  -> 32 rf writes with Reg[k]=k; 9 imem writes at addresses 0..8; dump sequence R0..R5 = 0,10,20,25,30,55; done=1, err=00.
- Same program with load_valid toggling 1,0,0,1.
  -> identical imem contents; 9 transfers; no dropped or duplicated word.
- dump_ready held 0 for 5 cycles on the third word.
  -> dump_idx=2 and dump_data=20 stable through the stall; 6 words total, then done.
- Core model never halts, TIMEOUT=50.
  -> core_run falls after 50 RUN cycles; err=10; run_cycles=50; no dump_valid.
- start with prog_len=0, then with prog_len=IMEM_DEPTH+1.
  -> immediate ERR with err=01; no rf or imem writes.
- rst asserted mid-LOAD after 4 words, then restart with prog_len=9.
  -> all outputs 0 the next cycle; the fresh session completes normally.
